mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port memory between two requesters of the pipelined MIPS machine: instruction fetch (I port) and the MEM stage (D port).
- Uses a 3-state grant FSM with registered grant decisions and variable-latency backend handshake. A bus timeout watchdog drives a sticky exception.
- Sits between the IF/MEM stages and the memory model. Requester ports return data and ready; the stages derive their stalls from these.

Parameters:
- ADDR_W, 32, address width (byte address; low 2 bits ignored, word access only).
- DATA_W, 32, data width.
- TIMEOUT, 64, max cycles a granted access waits for m_ready before abort; must be >= 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low (0 = reset).
- i_req  in  1  fetch read request; held with i_addr stable until i_ready.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetch data; valid when i_ready=1.
- i_ready  out  1  one-cycle completion pulse for the I port.
- d_req  in  1  data request; held with d_we/d_be/d_addr/d_wdata stable until d_ready.
- d_we  in  1  1 = write, 0 = read.
- d_be  in  4  byte enables, writes only.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  read data; valid when d_ready=1.
- d_ready  out  1  one-cycle completion pulse for the D port.
- m_valid  out  1  backend access active.
- m_we  out  1  backend write.
- m_be  out  4  backend byte enables (4'hF on reads).
- m_addr  out  ADDR_W  backend address.
- m_wdata  out  DATA_W  backend write data.
- m_rdata  in  DATA_W  backend read data; valid with m_ready.
- m_ready  in  1  backend completion, sampled only while m_valid=1.
- bus_except  out  1  sticky timeout flag; clears only on reset.

Behaviour:
- States: IDLE, GNT_I, GNT_D.
  - Registers: state, timeout counter (clog2(TIMEOUT)+1 bits), bus_except.
- Reset (reset==0 at a clock edge) forces the following, regardless of in-flight access; the aborted access never completes:
  - state=IDLE, counter=0, bus_except=0.
  - Outputs m_valid=0, i_ready=0, d_ready=0. i_rdata/d_rdata are don't-care.
- m_valid=1 exactly when state is GNT_I or GNT_D.
  - m_* fields are muxed combinationally from the granted port's live inputs.
  - In GNT_I: m_we=0, m_be=4'hF, m_wdata=0.
- IDLE transitions:
  - d_req=1 -> GNT_D (D has priority; it is the older instruction).
  - else i_req=1 -> GNT_I.
  - else stay in IDLE.
  - Latency: request seen in cycle N, m_valid=1 in cycle N+1.
- Completion: in GNT_x with m_ready=1 in cycle M:
  - x_ready=1 in cycle M (combinational). x_rdata=m_rdata; rdata is undefined for writes.
  - Next state at the M edge: the other port's grant if its req=1 (alternation, starvation-free). Otherwise IDLE.
  - The just-served port's req is ignored at this edge; the requester drops req after ready.
  - Back-to-back I/D alternation has zero bubble cycles.
- Only the granted port can see ready. The ungranted port's ready stays 0 even if m_ready=1.
- Timeout counter:
  - Cleared on entering any GNT state.
  - Increments each GNT cycle with m_ready=0.
  - Reaching TIMEOUT-1 with m_ready=0 triggers abort:
    - Pulse x_ready=1 with x_rdata=32'hDEADBEEF that cycle.
    - Set bus_except=1.
    - Next state follows the completion rule.
- m_ready in the abort cycle counts as a normal completion; no abort and no except.
- m_ready while IDLE is ignored.
- A requester dropping req mid-grant is a protocol violation; behaviour is undefined and need not be checked.

Decomposition:
- Shared package/defines (alongside mips_defines.v):
  - state encodings ARB_IDLE=2'd0, ARB_GNT_I=2'd1, ARB_GNT_D=2'd2.
  - constant ARB_ABORT_DATA=32'hDEADBEEF.
- One natural sub-module: arb_timeout_counter, holding clear/enable/expire logic parameterised by TIMEOUT.
- The FSM and muxes stay in the top level.

Test Plan:
- I-only read, backend m_ready 3 cycles after m_valid, m_rdata=32'h8C010004:
  - m_valid rises the cycle after i_req.
  - i_ready pulses 1 cycle with i_rdata=32'h8C010004.
  - Returns to IDLE; d_ready stays 0.
- Simultaneous i_req and d_req (D write, addr 0x100, be=4'b0011, wdata=32'h1234):
  - GNT_D first; m_we=1, m_be=4'b0011, m_addr=0x100.
  - On its m_ready, goes straight to GNT_I with no idle cycle.
  - i_ready follows.
- Continuous i_req and d_req with 1-cycle backend:
  - Grants strictly alternate D,I,D,I.
  - No port is served twice in a row while the other waits.
- Backend never asserts m_ready, TIMEOUT=8:
  - d_ready pulses on the 8th grant cycle with d_rdata=32'hDEADBEEF.
  - bus_except=1 and stays 1 through later successful accesses.
- m_ready arrives exactly in the 8th (abort) cycle: normal completion with m_rdata; bus_except stays 0.
- reset=0 during GNT_D wait:
  - After that edge: m_valid=0, d_ready=0, bus_except=0, state IDLE.
  - A late m_ready produces no ready pulse.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the instruction/data memory port arbiter.
//   arb_state_e  : grant FSM state encoding (idle, I granted, D granted)
//   ArbAbortData : read data returned to a requester whose access timed out
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ArbIdle = 2'd0,
        ArbGntI = 2'd1,
        ArbGntD = 2'd2
    } arb_state_e;

    localparam logic [31:0] ArbAbortData = 32'hDEADBEEF;

endpackage

// File: rtl/arb_timeout_counter.sv
// Bus watchdog for the memory port arbiter. Counts wait cycles of the current
// grant and flags the cycle in which the access must be aborted.
//   clk      : rising-edge clock
//   reset    : synchronous, active-low
//   clr_i    : restart the count (no grant, or access finishing this cycle)
//   inc_i    : a granted access is waiting on the backend this cycle
//   expire_o : this wait cycle is the last one allowed; abort now
module arb_timeout_counter #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic inc_i,
    output logic expire_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count value k means this is wait cycle k+1 of the grant.
    assign expire_o = inc_i && (cnt_q == CntLast);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (I port)
// and the MEM stage (D port). D wins when both request from idle; after a
// completion the other waiting port is granted with no bubble, so neither
// port can starve. A watchdog aborts accesses the backend never answers.
//   clk, reset                      : clock, synchronous active-low reset
//   i_req/i_addr -> i_rdata/i_ready : fetch read port
//   d_req/d_we/d_be/d_addr/d_wdata -> d_rdata/d_ready : data port
//   m_valid/m_we/m_be/m_addr/m_wdata, m_rdata/m_ready : memory backend
//   bus_except                      : sticky timeout flag, cleared by reset only
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              m_valid,
    output logic              m_we,
    output logic [3:0]        m_be,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    output logic              bus_except
);

    arb_state_e state_q, state_d;
    logic       bus_except_q, bus_except_d;

    logic gnt_i, gnt_d, busy, waiting, expire, done;

    assign gnt_i   = (state_q == ArbGntI);
    assign gnt_d   = (state_q == ArbGntD);
    assign busy    = gnt_i | gnt_d;
    assign waiting = busy & ~m_ready;
    // m_ready in the last allowed cycle wins over the abort.
    assign done    = busy & (m_ready | expire);

    arb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (~busy | done),
        .inc_i    (waiting),
        .expire_o (expire)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ArbIdle;
            bus_except_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus_except_q <= bus_except_d;
        end
    end

    // Next-state logic. The port just served is ignored at its completion
    // edge; its requester drops req after seeing ready.
    always_comb begin
        state_d      = state_q;
        bus_except_d = bus_except_q | expire;
        unique case (state_q)
            ArbIdle: begin
                if (d_req) begin
                    state_d = ArbGntD;
                end else if (i_req) begin
                    state_d = ArbGntI;
                end
            end
            ArbGntI: begin
                if (done) begin
                    state_d = d_req ? ArbGntD : ArbIdle;
                end
            end
            ArbGntD: begin
                if (done) begin
                    state_d = i_req ? ArbGntI : ArbIdle;
                end
            end
            default: state_d = ArbIdle;
        endcase
    end

    // Outputs: backend fields follow the granted port's live inputs.
    always_comb begin
        m_valid = busy;
        m_we    = 1'b0;
        m_be    = 4'hF;
        m_addr  = '0;
        m_wdata = '0;
        if (gnt_d) begin
            m_we    = d_we;
            m_be    = d_we ? d_be : 4'hF;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end else if (gnt_i) begin
            m_addr  = i_addr;
        end
        i_ready    = gnt_i & done;
        d_ready    = gnt_d & done;
        i_rdata    = expire ? DATA_W'(ArbAbortData) : m_rdata;
        d_rdata    = expire ? DATA_W'(ArbAbortData) : m_rdata;
        bus_except = bus_except_q;
    end

endmodule
